// File: rtl/result_display_driver.sv
`default_nettype none
// ============================================================================
//  Module   : result_display_driver
//  Purpose  : Shows the 32-bit processor result on an 8-digit, multiplexed,
//             active-low 7-segment display. A debounced freeze button holds
//             the shown value. A one-cycle pulse marks each change of the
//             sampled value.
//  Revision : 1.0  initial release
// ============================================================================
module result_display_driver #(
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result,
  input  logic        freeze_btn,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frozen,
  output logic        result_changed
);

  localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [31:0]      disp_val;
  logic [REF_W-1:0] refresh_cnt;
  logic [2:0]       idx;
  logic             btn_meta;
  logic             btn_sync;
  logic [DEB_W-1:0] deb_cnt;
  logic             btn_level;
  logic             btn_level_d;
  logic [3:0]       nibble;

  // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Nibble currently selected by the scan index
  assign nibble = disp_val[{idx, 2'b00} +: 4];

  // Two-flop synchronizer for the raw push-button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= freeze_btn;
      btn_sync <= btn_meta;
    end
  end

  // Accept a new button level only after it persists; any agreeing cycle restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
    end else if (btn_sync == btn_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt   <= '0;
      btn_level <= btn_sync;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Freeze FSM: each press (rising edge of the debounced level) toggles RUN/HOLD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      frozen      <= 1'b0;
      btn_level_d <= 1'b0;
    end else begin
      btn_level_d <= btn_level;
      if (btn_level && !btn_level_d) begin
        case (state)
          RUN: begin
            state  <= HOLD;
            frozen <= 1'b1;
          end
          HOLD: begin
            state  <= RUN;
            frozen <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sample the result bus while running and flag a changed value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_val       <= '0;
      result_changed <= 1'b0;
    end else if (!frozen) begin
      disp_val       <= result;
      result_changed <= (result != disp_val);
    end else begin
      result_changed <= 1'b0;
    end
  end

  // Refresh timer: advance to the next digit at terminal count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      idx         <= 3'd0;
    end else if (refresh_cnt == REF_LAST) begin
      refresh_cnt <= '0;
      idx         <= idx + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Registered display drive from the current digit index and held value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'h01 << idx);
      seg <= hex_to_seg(nibble);
      dp  <= ~((idx == 3'd0) && frozen);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_display_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_display_driver
//  Purpose  : Self-checking bench for result_display_driver with a cycle-level
//             reference model, constant digit tables and corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_result_display_driver;

  localparam int RD = 4;
  localparam int DC = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] result;
  logic        freeze_btn;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frozen;
  logic        result_changed;

  always #5 clk = ~clk;

  result_display_driver #(
    .REFRESH_DIV    (RD),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .result        (result),
    .freeze_btn    (freeze_btn),
    .an            (an),
    .seg           (seg),
    .dp            (dp),
    .frozen        (frozen),
    .result_changed(result_changed)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  logic [31:0] m_disp;
  bit          m_frozen, m_deb, m_pend;
  int          m_t;
  bit          hist[$];
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_chg, e_frozen;

  typedef struct {
    logic [31:0] value;
    int          digit;
    logic [7:0]  an;
    logic [6:0]  seg;
  } vec_t;
  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_disp = 32'h0; m_frozen = 0; m_deb = 0; m_pend = 0; m_t = 0;
    hist.delete();
  endtask

  // One clock edge of the model; inputs are the values present at the edge
  task automatic model_edge();
    int j, idx;
    bit all_diff, b;
    logic [3:0] nib;
    j   = m_t + 1;
    idx = ((j - 1) / RD) % 8;
    nib = 4'(m_disp >> (4 * idx));
    e_an  = ~(8'h01 << idx);
    e_seg = hex_tbl[nib];
    e_dp  = !(idx == 0 && m_frozen);
    e_chg = !m_frozen && (result != m_disp);
    if (!m_frozen) m_disp = result;
    // debounced level flips once the synced button (2 edges late) disagreed for DC edges
    all_diff = 1;
    for (int k = j - DC - 1; k <= j - 2; k++) begin
      b = (k >= 1) ? hist[k-1] : 1'b0;
      if (b == m_deb) all_diff = 0;
    end
    if (m_pend) m_frozen = !m_frozen;
    m_pend = 0;
    if (all_diff) begin
      m_deb  = !m_deb;
      m_pend = m_deb;
    end
    e_frozen = m_frozen;
    hist.push_back(freeze_btn);
    m_t = j;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, e_dp);
    chk("frozen", frozen, e_frozen);
    chk("result_changed", result_changed, e_chg);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"}, an, 8'hFF);
    chk({tag, "_seg"}, seg, 7'h7F);
    chk({tag, "_dp"}, dp, 1'b1);
    chk({tag, "_frozen"}, frozen, 1'b0);
    chk({tag, "_chg"}, result_changed, 1'b0);
  endtask

  task automatic do_reset(input logic [31:0] val);
    @(negedge clk);
    reset = 1'b0; result = val; freeze_btn = 1'b0;
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  // Step until the displayed digit is d in the middle of its window
  task automatic wait_digit(input int d);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!((m_t % RD) == 3 && (((m_t - 1) / RD) % 8) == d) && n < 40);
    if (n >= 40) chk("digit_wait_timeout", 0, 1);
  endtask

  task automatic check_vec(input int i);
    wait_digit(vt[i].digit);
    chk($sformatf("tbl%0d_an", i), an, vt[i].an);
    chk($sformatf("tbl%0d_seg", i), seg, vt[i].seg);
  endtask

  // Hold the button for n cycles, return edge count until frozen changes (0 = never)
  task automatic press(input int n, output int lat, inout int pulses);
    logic f0;
    f0 = frozen; lat = 0;
    freeze_btn = 1'b1;
    for (int s = 1; s <= n; s++) begin
      step();
      if (result_changed) pulses++;
      if (lat == 0 && frozen != f0) lat = s;
    end
    freeze_btn = 1'b0;
  endtask

  task automatic idle(input int n, inout int pulses);
    for (int s = 0; s < n; s++) begin
      step();
      if (result_changed) pulses++;
    end
  endtask

  initial begin
    int lat, pulses, hold_left;
    logic f_before;

    vt[0]  = '{32'h12345678, 0, 8'hFE, 7'h00};
    vt[1]  = '{32'h12345678, 1, 8'hFD, 7'h78};
    vt[2]  = '{32'h12345678, 2, 8'hFB, 7'h02};
    vt[3]  = '{32'h12345678, 3, 8'hF7, 7'h12};
    vt[4]  = '{32'h12345678, 4, 8'hEF, 7'h19};
    vt[5]  = '{32'h12345678, 5, 8'hDF, 7'h30};
    vt[6]  = '{32'h12345678, 6, 8'hBF, 7'h24};
    vt[7]  = '{32'h12345678, 7, 8'h7F, 7'h79};
    vt[8]  = '{32'hDEADBEEF, 0, 8'hFE, 7'h0E};
    vt[9]  = '{32'hDEADBEEF, 1, 8'hFD, 7'h06};
    vt[10] = '{32'hDEADBEEF, 2, 8'hFB, 7'h06};
    vt[11] = '{32'hDEADBEEF, 3, 8'hF7, 7'h03};
    vt[12] = '{32'hDEADBEEF, 4, 8'hEF, 7'h21};
    vt[13] = '{32'hDEADBEEF, 5, 8'hDF, 7'h08};
    vt[14] = '{32'hDEADBEEF, 6, 8'hBF, 7'h06};
    vt[15] = '{32'hDEADBEEF, 7, 8'h7F, 7'h21};

    reset = 1'b0; result = 32'h12345678; freeze_btn = 1'b0;
    model_reset();

    // Test 1: reset values, scan order and wrap
    do_reset(32'h12345678);
    step();
    chk("first_an", an, 8'hFE);
    for (int i = 0; i < 8; i++) check_vec(i);
    while (m_t < 8 * RD + 1) step();
    chk("wrap_an", an, 8'hFE);

    // Test 2: change pulse on 0 -> DEADBEEF and its digits
    do_reset(32'h0);
    step(); step();
    result = 32'hDEADBEEF;
    step();
    chk("chg_pulse", result_changed, 1'b1);
    step();
    chk("chg_drop", result_changed, 1'b0);
    for (int i = 8; i < 16; i++) check_vec(i);

    // Test 3: clean press freezes after DC+3 edges; new result is ignored
    pulses = 0;
    press(12, lat, pulses);
    chk("freeze_latency", lat, DC + 3);
    result = 32'hCAFE0000;
    pulses = 0;
    idle(14, pulses);
    chk("frozen_no_pulse", pulses, 0);
    wait_digit(0);
    chk("dp_frozen_d0", dp, 1'b0);
    wait_digit(7);
    chk("held_digit7", seg, 7'h21);

    // Test 4: glitchy press is ignored, clean press unfreezes
    f_before = frozen;
    freeze_btn = 1'b1; idle(5, pulses);
    freeze_btn = 1'b0; idle(1, pulses);
    freeze_btn = 1'b1; idle(5, pulses);
    freeze_btn = 1'b0; idle(12, pulses);
    chk("glitch_ignored", frozen, f_before);
    pulses = 0;
    press(12, lat, pulses);
    chk("unfreeze_latency", lat, DC + 3);
    idle(14, pulses);
    chk("unfreeze_one_pulse", pulses, 1);
    wait_digit(7);
    chk("cafe_digit7", seg, 7'h46);

    // Test 5: asynchronous reset mid-scan while frozen
    press(12, lat, pulses);
    idle(14, pulses);
    chk("refrozen", frozen, 1'b1);
    wait_digit(5);
    chk("mid_scan_an", an, 8'hDF);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("restart_an", an, 8'hFE);

    // Randomized traffic against the model
    hold_left = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) result = $urandom;
      if (hold_left == 0) begin
        freeze_btn = ~freeze_btn;
        hold_left = $urandom_range(1, 14);
      end
      hold_left--;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
